// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver with a double-buffered valid/ready output register.
// Optional even-parity bit after each word is enabled by defining SIPO_PARITY_CHECK_EN.
module sipo_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_sync_reset,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  input  logic             i_frame_start,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_overrun,
  output logic             o_frame_err,
  output logic             o_parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_start;
  logic             w_last_data;
  logic             w_complete;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_cword;

  // A frame_start bit always begins from an empty register, which also covers the abort case.
  always_comb begin
    w_start     = i_ser_valid & i_frame_start;
    w_base      = w_start ? '0 : r_shift;
    w_next      = LSB_FIRST ? {i_ser_in, w_base[WIDTH-1:1]} : {w_base[WIDTH-2:0], i_ser_in};
    w_last_data = (r_state == SHIFT) & i_ser_valid & ~i_frame_start & (r_count == LAST);
`ifdef SIPO_PARITY_CHECK_EN
    w_complete  = (r_state == PARITY) & i_ser_valid & ~i_frame_start;
    w_cword     = r_shift;
`else
    w_complete  = w_last_data;
    w_cword     = w_next;
`endif
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic r_parity_err;
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_sync_reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_state     <= SHIFT;
        r_shift     <= w_next;
        r_count     <= ONE;
        r_frame_err <= (r_state != IDLE);
      end else if (i_ser_valid) begin
        case (r_state)
          SHIFT: begin
            r_shift <= w_next;
            r_count <= r_count + ONE;
`ifdef SIPO_PARITY_CHECK_EN
            if (w_last_data) r_state <= PARITY;
`else
            if (w_last_data) r_state <= IDLE;
`endif
          end
`ifdef SIPO_PARITY_CHECK_EN
          PARITY: r_state <= IDLE;
`endif
          default: ;
        endcase
      end

      // A completing word loads only if the slot is free or being drained this edge.
      if (w_complete) begin
        if (!r_valid || i_out_ready) begin
          r_data  <= w_cword;
          r_valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
          r_parity_err <= ^{r_shift, i_ser_in};
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Bench for sipo_frame_receiver: two instances (LSB-first and MSB-first) fed the same stream,
// checked each cycle against a bit-queue frame model; honours SIPO_PARITY_CHECK_EN.
module tb_sipo_frame_receiver;
  localparam int W = 8;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ser_in = 1'b0, ser_valid = 1'b0, fs = 1'b0, ready = 1'b0;
  logic [W-1:0] d1, d0;
  logic v1, v0, ov1, ov0, fe1, fe0, pe1, pe0;

  always #5 clk = ~clk;

  sipo_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_sync_reset(rst_n), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
    .i_frame_start(fs), .o_out_data(d1), .o_out_valid(v1), .i_out_ready(ready),
    .o_overrun(ov1), .o_frame_err(fe1), .o_parity_err(pe1));

  sipo_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_sync_reset(rst_n), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
    .i_frame_start(fs), .o_out_data(d0), .o_out_valid(v0), .i_out_ready(ready),
    .o_overrun(ov0), .o_frame_err(fe0), .o_parity_err(pe0));

  int checks = 0;
  int failures = 0;

  // Reference model: bits of the frame in arrival order, plus the output slot.
  bit           q[$];
  bit           in_frame = 0;
  bit           m_valid = 0, m_ov = 0, m_fe = 0, m_pe = 0;
  logic [W-1:0] m_d1 = '0, m_d0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit complete;
    bit par;
    logic [W-1:0] w1, w0;
    m_ov = 0;
    m_fe = 0;
    complete = 0;
    if (!rst_n) begin
      q.delete();
      in_frame = 0;
      m_valid = 0; m_d1 = '0; m_d0 = '0; m_pe = 0;
      return;
    end
    if (ser_valid && fs) begin
      m_fe = in_frame;
      q.delete();
      q.push_back(ser_in);
      in_frame = 1;
    end else if (ser_valid && in_frame) begin
      q.push_back(ser_in);
      if (q.size() == FLEN) complete = 1;
    end
    if (complete) begin
      par = 0;
      for (int i = 0; i < W; i++) begin
        w1[i]       = q[i];
        w0[W-1-i]   = q[i];
      end
      for (int i = 0; i < FLEN; i++) par ^= q[i];
      q.delete();
      in_frame = 0;
      if (m_valid && !ready) m_ov = 1;
      else begin
        m_valid = 1; m_d1 = w1; m_d0 = w0;
        m_pe = (FLEN > W) ? par : 1'b0;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("valid_lsb", {31'd0, v1}, {31'd0, m_valid});
    chk("valid_msb", {31'd0, v0}, {31'd0, m_valid});
    chk("overrun_lsb", {31'd0, ov1}, {31'd0, m_ov});
    chk("overrun_msb", {31'd0, ov0}, {31'd0, m_ov});
    chk("frame_err_lsb", {31'd0, fe1}, {31'd0, m_fe});
    chk("frame_err_msb", {31'd0, fe0}, {31'd0, m_fe});
    if (m_valid || !rst_n) begin
      chk("data_lsb", {24'd0, d1}, {24'd0, m_d1});
      chk("data_msb", {24'd0, d0}, {24'd0, m_d0});
      chk("parity_lsb", {31'd0, pe1}, {31'd0, m_pe});
      chk("parity_msb", {31'd0, pe0}, {31'd0, m_pe});
    end
  endtask

  task automatic step(input bit v, input bit f, input bit b);
    ser_valid = v; fs = f; ser_in = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // bits[i] is the i-th bit on the line; stalls inserted after stall_after bits.
  task automatic send_frame(input logic [W-1:0] bits, input int stall_after, input int stall_len,
                            input bit par);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, bits[i]);
      if (i == stall_after - 1)
        for (int s = 0; s < stall_len; s++) step(1'b0, 1'b0, 1'($urandom));
    end
    if (FLEN > W) step(1'b1, 1'b0, par);
  endtask

  initial begin
    bit v, f;
    logic [W-1:0] w;

    rst_n = 1'b0;
    step(0, 0, 0);
    step(1, 1, 1);
    chk("reset_valid", {31'd0, v1}, 32'd0);
    chk("reset_data", {24'd0, d1}, 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0);

    ready = 1'b1;
    send_frame(8'hA5, 0, 0, ^8'hA5);
    chk("a5_lsb_data", {24'd0, d1}, 32'hA5);
    chk("a5_lsb_valid", {31'd0, v1}, 32'd1);
    step(0, 0, 0);
    chk("a5_consumed", {31'd0, v1}, 32'd0);

    send_frame(8'hA5, 4, 3, ^8'hA5);
    chk("a5_stall_data", {24'd0, d1}, 32'hA5);
    step(0, 0, 0);

    send_frame(8'h83, 0, 0, ^8'h83);
    chk("c1_msb_data", {24'd0, d0}, 32'hC1);
    step(0, 0, 0);

    ready = 1'b0;
    send_frame(8'h3C, 0, 0, ^8'h3C);
    send_frame(8'hFF, 0, 0, ^8'hFF);
    chk("overrun_pulse", {31'd0, ov1}, 32'd1);
    chk("overrun_hold", {24'd0, d1}, 32'h3C);
    step(0, 0, 0);
    chk("overrun_one_cycle", {31'd0, ov1}, 32'd0);
    ready = 1'b1;
    step(0, 0, 0);
    chk("overrun_drain", {31'd0, v1}, 32'd0);

    for (int i = 0; i < 5; i++) step(1, i == 0, 1'($urandom));
    step(1, 1, 0);
    chk("abort_pulse", {31'd0, fe1}, 32'd1);
    for (int i = 1; i < W; i++) step(1, 0, (8'h5A >> i) & 1);
    if (FLEN > W) step(1, 0, ^8'h5A);
    chk("abort_data", {24'd0, d1}, 32'h5A);
    step(0, 0, 0);

    for (int i = 0; i < 3; i++) step(1, i == 0, 1'($urandom));
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    w = 8'($urandom);
    send_frame(w, 0, 0, ^w);
    chk("post_reset_data", {24'd0, d1}, {24'd0, w});
    step(0, 0, 0);

`ifdef SIPO_PARITY_CHECK_EN
    send_frame(8'hA5, 0, 0, 1'b0);
    chk("parity_ok", {31'd0, pe1}, 32'd0);
    chk("parity_ok_valid", {31'd0, v1}, 32'd1);
    send_frame(8'hA5, 0, 0, 1'b1);
    chk("parity_bad", {31'd0, pe1}, 32'd1);
    chk("parity_bad_valid", {31'd0, v1}, 32'd1);
    step(0, 0, 0);
`endif

    for (int n = 0; n < 4000; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      v = ($urandom_range(0, 3) != 0);
      f = v && (in_frame ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0));
      step(v, f, 1'($urandom));
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Serial-to-parallel receiver: the receiving end of the shift-register serial link. Collects WIDTH bits from a serial line, qualified per bit, into an internal shift register.
- Each completed word goes to a double-buffered output register with a valid/ready handshake.
- Sits downstream of a parallel-load shift-register transmitter. Delivers words to parallel consumer logic.

Parameters:
- WIDTH, 8, data word width in bits (≥2)
- LSB_FIRST, 1, 1: first received bit lands in out_data[0]; 0: first received bit lands in out_data[WIDTH-1]

Ports:
- clk  input  1  single clock, all logic on rising edge
- sync_reset  input  1  reset, synchronous, active-low (0 = reset on the clk edge)
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in holds a valid bit this cycle
- frame_start  input  1  marks the current valid bit as bit 0 of a new frame; ignored when ser_valid=0
- out_data  output  WIDTH  received word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data when out_valid=1
- overrun  output  1  one-cycle pulse: completed word dropped
- frame_err  output  1  one-cycle pulse: partial frame aborted by frame_start
- parity_err  output  1  parity flag for the word in out_data (see Optional Feature)

Behaviour:
- Reset (sync_reset=0 at an edge):
  - State IDLE; shift register, bit counter and out_data cleared to 0.
  - out_valid, overrun, frame_err and parity_err all 0.
  - Reset mid-frame discards the partial frame; no error pulse.
- States: IDLE, SHIFT, plus PARITY when the Optional Feature is enabled.
- IDLE:
  - Bits with ser_valid=1 and frame_start=0 are ignored.
  - ser_valid=1 and frame_start=1: capture ser_in as bit 0, set count=1, go to SHIFT.
- SHIFT:
  - Each ser_valid=1 cycle captures one bit and increments count.
  - A cycle with ser_valid=0 stalls; count and shift register hold.
- Bit placement:
  - LSB_FIRST=1: shift right, new bit enters at MSB; after WIDTH bits, bit 0 sits at index 0.
  - LSB_FIRST=0: shift left, new bit enters at LSB.
- Frame completion: the cycle capturing bit WIDTH-1 is the completion cycle (feature disabled). That cycle:
  - Loads the assembled word (including this bit) into out_data on that edge, so out_valid=1 the following cycle. Latency from last bit = 1 cycle.
  - Returns the state machine to IDLE.
  - The next frame may start on the very next cycle; zero-gap back-to-back frames are supported.
- Handshake:
  - An out_valid=1 && out_ready=1 edge consumes the word; out_valid clears unless a new word loads on the same edge.
  - out_data is stable while out_valid=1 and not consumed.
- Overrun:
  - Condition: completion while out_valid=1 && out_ready=0.
  - The new word is dropped; out_data/out_valid are unchanged; overrun pulses 1 cycle.
  - Completion while out_valid=1 && out_ready=1: the old word is consumed, the new word loads, out_valid stays 1, no overrun.
- Abort:
  - frame_start=1 with ser_valid=1 while in SHIFT (count≥1) discards the partial frame and pulses frame_err for 1 cycle.
  - The current bit becomes bit 0 of the new frame (count=1).
  - frame_start on the bit that would be the completion bit counts as an abort, not a completion.
- Counter width: clog2(WIDTH+1); wrap is never reached because count resets on completion or abort.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits, the FSM enters PARITY; the next ser_valid bit is the even-parity bit.
  - The completion cycle becomes that parity-bit cycle.
  - parity_err loads with out_data: 1 if XOR(data bits, parity bit)=1.
  - frame_start during PARITY aborts as in SHIFT.
  - Overrun and handshake rules are unchanged.
- Not defined: the PARITY state is absent and parity_err is constant 0.

Test Plan:
- WIDTH=8, LSB_FIRST=1; bits 1,0,1,0,0,1,0,1 on consecutive cycles, frame_start on the first, out_ready=1 -> out_data=0xA5 and out_valid=1 one cycle after the 8th bit; out_valid=0 the next cycle.
- Same 0xA5 frame with ser_valid=0 for 3 cycles after bit 4 -> no change during the stall; out_data=0xA5 one cycle after the 8th bit.
- LSB_FIRST=0; bits 1,1,0,0,0,0,0,1 -> out_data=0xC1.
- out_ready=0; frames 0x3C then 0xFF back-to-back -> out_data=0x3C held, overrun pulses 1 cycle at the 0xFF completion. Raising out_ready then -> out_valid=0.
- frame_start after 5 bits of a frame, then 8 bits of 0x5A -> frame_err pulses 1 cycle at the abort; out_data=0x5A. Separately, sync_reset=0 after 3 bits -> all outputs 0, and the next full frame is received correctly.
- With SIPO_PARITY_CHECK_EN: 0xA5 then parity bit 0 -> parity_err=0. 0xA5 then parity bit 1 -> parity_err=1, with out_valid one cycle after the parity bit.
